keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: drives one column low at a time, debounces
// presses/releases, and holds the accepted key until acknowledged.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   row_n[3:0] keypad rows, active-low, asynchronous to clk
//   col_n[3:0] column drive, active-low, one-cold
//   key_code   accepted key {row_idx, col_idx}
//   key_valid  key_code holds an unconsumed key
//   key_ack    consumer accepts key_code
//   busy       high whenever not scanning
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       busy
);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        VALID,
        RELEASE
    } state_e;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  sync1_q;
    logic [3:0]  rows_s_q;
    logic [1:0]  col_q, col_d;
    logic [15:0] div_q, div_d;
    logic [19:0] deb_q, deb_d;
    logic [3:0]  cap_q, cap_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic [1:0]  row_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SCAN;
            sync1_q  <= 4'b1111;
            rows_s_q <= 4'b1111;
            col_q    <= 2'd0;
            div_q    <= 16'd0;
            deb_q    <= 20'd0;
            cap_q    <= 4'b1111;
            code_q   <= 4'h0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= row_n;
            rows_s_q <= sync1_q;
            col_q    <= col_d;
            div_q    <= div_d;
            deb_q    <= deb_d;
            cap_q    <= cap_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
        end
    end

    // Lowest-index pressed row wins when several rows are low.
    always_comb begin
        row_idx = 2'd3;
        if (!cap_q[0])      row_idx = 2'd0;
        else if (!cap_q[1]) row_idx = 2'd1;
        else if (!cap_q[2]) row_idx = 2'd2;
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        div_d   = div_q;
        deb_d   = deb_q;
        cap_d   = cap_q;
        code_d  = code_q;
        valid_d = valid_q;
        unique case (state_q)
            SCAN: begin
                // Rows are only trusted in the last dwell cycle, after
                // the new column drive has settled through the syncs.
                if (div_q == DIV_LAST) begin
                    div_d = 16'd0;
                    if (rows_s_q != 4'b1111) begin
                        cap_d   = rows_s_q;
                        deb_d   = 20'd0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            DEBOUNCE: begin
                if (rows_s_q != cap_q) begin
                    state_d = SCAN;
                    div_d   = 16'd0;
                    deb_d   = 20'd0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = VALID;
                    code_d  = {row_idx, col_q};
                    valid_d = 1'b1;
                    deb_d   = 20'd0;
                end else begin
                    deb_d = deb_q + 20'd1;
                end
            end
            VALID: begin
                if (key_ack) begin
                    valid_d = 1'b0;
                    deb_d   = 20'd0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (rows_s_q != 4'b1111) begin
                    deb_d = 20'd0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = SCAN;
                    div_d   = 16'd0;
                    deb_d   = 20'd0;
                end else begin
                    deb_d = deb_q + 20'd1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign col_n     = ~(4'b0001 << col_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign busy      = (state_q != SCAN);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4,
// DEBOUNCE_CYCLES=3: cycle-step table plus async reset sequence.
module tb_keypad_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       busy;

    int total;
    int bad;

    keypad_scan_ctrl #(
        .SCAN_DIV(4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row_n(row_n),
        .col_n(col_n),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_ack(key_ack),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] row;
        logic       ack;
        int         n;
        logic [3:0] col;
        logic       v;
        logic       b;
        logic [3:0] code;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] row, input logic ack,
                       input int n, input logic [3:0] col,
                       input logic v, input logic b,
                       input logic [3:0] code);
        vec_t t;
        t.row  = row;
        t.ack  = ack;
        t.n    = n;
        t.col  = col;
        t.v    = v;
        t.b    = b;
        t.code = code;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [3:0] got,
                       input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] col,
                           input logic v, input logic b,
                           input logic [3:0] code);
        chk({tag, " col_n"}, col_n, col);
        chk({tag, " key_valid"}, {3'b000, key_valid}, {3'b000, v});
        chk({tag, " busy"}, {3'b000, busy}, {3'b000, b});
        chk({tag, " key_code"}, key_code, code);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        row_n   = 4'hF;
        key_ack = 1'b0;

        // k = edges since reset release, checked #1 after edge k
        // idle scan
        add(4'hF, 0, 1, 4'hE, 0, 0, 4'h0);   // k1
        add(4'hF, 0, 2, 4'hE, 0, 0, 4'h0);   // k3
        add(4'hF, 0, 1, 4'hD, 0, 0, 4'h0);   // k4
        add(4'hF, 0, 4, 4'hB, 0, 0, 4'h0);   // k8
        add(4'hF, 0, 4, 4'h7, 0, 0, 4'h0);   // k12
        add(4'hF, 0, 4, 4'hE, 0, 0, 4'h0);   // k16
        add(4'hF, 0, 4, 4'hD, 0, 0, 4'h0);   // k20
        add(4'hF, 0, 4, 4'hB, 0, 0, 4'h0);   // k24
        add(4'hF, 0, 4, 4'h7, 0, 0, 4'h0);   // k28
        add(4'hF, 0, 4, 4'hE, 0, 0, 4'h0);   // k32
        add(4'hF, 0, 8, 4'hB, 0, 0, 4'h0);   // k40
        // row1 on col2 -> code 6
        add(4'hD, 0, 3, 4'hB, 0, 0, 4'h0);   // k43
        add(4'hD, 0, 1, 4'hB, 0, 1, 4'h0);   // k44
        add(4'hD, 0, 2, 4'hB, 0, 1, 4'h0);   // k46
        add(4'hD, 0, 1, 4'hB, 1, 1, 4'h6);   // k47
        add(4'hF, 0, 10, 4'hB, 1, 1, 4'h6);  // k57 held w/o ack
        add(4'hF, 1, 1, 4'hB, 0, 1, 4'h6);   // k58 ack
        add(4'hF, 0, 2, 4'hB, 0, 1, 4'h6);   // k60
        add(4'hF, 0, 1, 4'hB, 0, 0, 4'h6);   // k61 back to scan
        add(4'hF, 0, 3, 4'hB, 0, 0, 4'h6);   // k64 fresh dwell
        add(4'hF, 0, 1, 4'h7, 0, 0, 4'h6);   // k65
        // 2-cycle glitch on col0
        add(4'hF, 0, 4, 4'hE, 0, 0, 4'h6);   // k69
        add(4'hE, 0, 2, 4'hE, 0, 0, 4'h6);   // k71
        add(4'hF, 0, 2, 4'hE, 0, 1, 4'h6);   // k73 debounce
        add(4'hF, 0, 1, 4'hE, 0, 0, 4'h6);   // k74 aborted
        add(4'hF, 0, 3, 4'hE, 0, 0, 4'h6);   // k77
        add(4'hF, 0, 1, 4'hD, 0, 0, 4'h6);   // k78
        // rows 0,1 on col3 -> code 3
        add(4'hF, 0, 8, 4'h7, 0, 0, 4'h6);   // k86
        add(4'hC, 0, 4, 4'h7, 0, 1, 4'h6);   // k90
        add(4'hC, 0, 3, 4'h7, 1, 1, 4'h3);   // k93
        add(4'hC, 1, 1, 4'h7, 0, 1, 4'h3);   // k94 ack
        add(4'hC, 0, 5, 4'h7, 0, 1, 4'h3);   // k99 still held
        add(4'hF, 0, 4, 4'h7, 0, 1, 4'h3);   // k103
        add(4'hF, 0, 1, 4'h7, 0, 0, 4'h3);   // k104
        add(4'hF, 1, 2, 4'h7, 0, 0, 4'h3);   // k106 stray ack
        add(4'hF, 0, 2, 4'hE, 0, 0, 4'h3);   // k108
        // row2 on col0 -> code 8
        add(4'hB, 0, 7, 4'hE, 1, 1, 4'h8);   // k115

        #2;
        chk_all("reset", 4'hE, 1'b0, 1'b0, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            row_n   = tbl[i].row;
            key_ack = tbl[i].ack;
            repeat (tbl[i].n) @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), tbl[i].col,
                    tbl[i].v, tbl[i].b, tbl[i].code);
        end

        // async half-cycle reset while key_valid is high
        row_n   = 4'hF;
        key_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'hE, 1'b0, 1'b0, 4'h0);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all("post_rst k3", 4'hE, 1'b0, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        chk_all("post_rst k4", 4'hD, 1'b0, 1'b0, 4'h0);
        for (int c = 0; c < 36; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle%0d key_valid", c),
                {3'b000, key_valid}, 4'h0);
            chk($sformatf("idle%0d busy", c),
                {3'b000, busy}, 4'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
